// File: rtl/packetizer_pkg.sv
// Shared flit geometry and formatting helpers for the packetizer/depacketizer pair.
package packetizer_pkg;

  localparam int unsigned FlitsPerPkt = 4;
  // Upper bound on a single flit; formatting helpers work at this width and callers truncate.
  localparam int unsigned MaxFlitW    = 512;

  // Control bit offsets counted down from the flit MSB; dest follows immediately after.
  localparam int unsigned ValidOfs    = 0;
  localparam int unsigned HeadOfs     = 1;
  localparam int unsigned TailOfs     = 2;
  localparam int unsigned HdrCtrlBits = 3;

  typedef struct packed {
    int payload_w;
    int num_flits;
  } flit_geom_t;

  function automatic int unsigned flit_width(int unsigned width_out);
    return width_out / FlitsPerPkt;
  endfunction

  // Payload bits per flit and flits per packet; payload_w < 1 marks an unusable geometry.
  function automatic flit_geom_t calc_geom(int unsigned width_in, int unsigned width_out,
                                           int unsigned addr_w, int unsigned vc_w);
    flit_geom_t g;
    g.payload_w = int'(flit_width(width_out)) - int'(HdrCtrlBits) - int'(addr_w) - int'(vc_w);
    g.num_flits = (g.payload_w > 0) ? (int'(width_in) + g.payload_w - 1) / g.payload_w : 0;
    return g;
  endfunction

  // Right-aligned flit: valid, head, tail, dest, vc, payload from MSB down to bit 0.
  function automatic logic [MaxFlitW-1:0] build_flit(logic valid, logic head, logic tail,
                                                     logic [31:0] dest, logic [31:0] vc,
                                                     logic [MaxFlitW-1:0] payload,
                                                     int unsigned flit_w, int unsigned addr_w,
                                                     int unsigned vc_w);
    logic [MaxFlitW-1:0] one;
    logic [MaxFlitW-1:0] flit;
    int unsigned         pay_w;
    one   = 1;
    pay_w = flit_w - HdrCtrlBits - addr_w - vc_w;
    flit  = payload & ((one << pay_w) - one);
    flit |= (MaxFlitW'(vc) & ((one << vc_w) - one)) << pay_w;
    flit |= (MaxFlitW'(dest) & ((one << addr_w) - one)) << (pay_w + vc_w);
    flit |= MaxFlitW'(tail) << (flit_w - 1 - TailOfs);
    flit |= MaxFlitW'(head) << (flit_w - 1 - HeadOfs);
    flit |= MaxFlitW'(valid) << (flit_w - 1 - ValidOfs);
    return flit;
  endfunction

endpackage

// File: rtl/pkt_skid_buffer.sv
// Two-entry ready/valid register slice: a main output register plus one skid register.
module pkt_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] main_data_q, main_data_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             ready_q;
  logic             accept;
  logic             pop;

  assign accept  = valid_i & ready_q;
  assign pop     = main_valid_q & ready_i;
  assign ready_o = ready_q;
  assign valid_o = main_valid_q;
  assign data_o  = main_data_q;

  // Next-state: refill main from skid first (keeps order), else from input; overflow to skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop || !main_valid_q) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = data_i;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  // State registers; ready is registered so it never depends combinationally on ready_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ~skid_valid_d;
    end
  end

endmodule

// File: rtl/packetizer.sv
// Packs a user word into up to four fabric flits and registers it through a skid buffer.
module packetizer
  import packetizer_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned WIDTH_IN         = 19,
  parameter int unsigned WIDTH_OUT        = 512,
  parameter int unsigned ASSIGNED_VC      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH_IN-1:0]      i_data_in,
  input  logic [ADDRESS_WIDTH-1:0] i_dest_in,
  input  logic                     i_valid_in,
  output logic                     i_ready_out,
  output logic [WIDTH_OUT-1:0]     o_data_out,
  output logic                     o_valid_out,
  input  logic                     o_ready_in
);

  localparam int unsigned FLIT_W = flit_width(WIDTH_OUT);
  localparam flit_geom_t  Geom   = calc_geom(WIDTH_IN, WIDTH_OUT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int          P      = Geom.payload_w;
  localparam int          NF     = Geom.num_flits;
  localparam int unsigned PadW   = NF * P;

  if (NF > 4 || P < 1 || FLIT_W > MaxFlitW) begin : g_bad_params
    $fatal(1, "packetizer: parameters give an unsupported flit geometry");
  end

  logic [PadW-1:0]      data_pad;
  logic [WIDTH_OUT-1:0] pkt;

  // Zero-extend so the last flit's payload slice never reads past the user word.
  assign data_pad = PadW'(i_data_in);

  // Combinational formatting: flit 0 at the MSBs, unused trailing flits left at zero.
  always_comb begin
    pkt = '0;
    for (int k = 0; k < NF; k++) begin
      pkt[WIDTH_OUT-1-k*FLIT_W -: FLIT_W] = FLIT_W'(build_flit(
          1'b1, (k == 0), (k == NF - 1), 32'(i_dest_in), ASSIGNED_VC,
          MaxFlitW'(data_pad[k*P +: P]), FLIT_W, ADDRESS_WIDTH, VC_ADDRESS_WIDTH));
    end
  end

  pkt_skid_buffer #(
    .Width(WIDTH_OUT)
  ) u_skid (
    .clk_i  (clk),
    .rst_ni (rst),
    .valid_i(i_valid_in),
    .ready_o(i_ready_out),
    .data_i (pkt),
    .valid_o(o_valid_out),
    .ready_i(o_ready_in),
    .data_o (o_data_out)
  );

endmodule

// File: tb/tb_packetizer.sv
// Randomised bench for packetizer: a default (single-flit) and a 300-bit (3-flit) instance.
module tb_packetizer;

  logic         clk;
  logic         rst;

  logic [18:0]  a_data;
  logic [3:0]   a_dest;
  logic         a_vin, a_rdy_out, a_vout, a_rdy_in;
  logic [511:0] a_dout;

  logic [299:0] b_data;
  logic [3:0]   b_dest;
  logic         b_vin, b_rdy_out, b_vout, b_rdy_in;
  logic [511:0] b_dout;

  logic [511:0] qa[$];
  logic [511:0] qb[$];
  logic         armed;
  int           tests;
  int           fails;

  packetizer u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .i_data_in  (a_data),
    .i_dest_in  (a_dest),
    .i_valid_in (a_vin),
    .i_ready_out(a_rdy_out),
    .o_data_out (a_dout),
    .o_valid_out(a_vout),
    .o_ready_in (a_rdy_in)
  );

  packetizer #(
    .WIDTH_IN(300)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .i_data_in  (b_data),
    .i_dest_in  (b_dest),
    .i_valid_in (b_vin),
    .i_ready_out(b_rdy_out),
    .o_data_out (b_dout),
    .o_valid_out(b_vout),
    .o_ready_in (b_rdy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference packet for default geometry: 128-bit flits, 120-bit payload, vc 0.
  function automatic logic [511:0] model_pkt(input logic [299:0] data, input logic [3:0] dest,
                                             input int win);
    logic [511:0] pkt;
    logic [119:0] pay;
    int           nf;
    nf  = (win + 119) / 120;
    pkt = '0;
    for (int k = 0; k < nf; k++) begin
      pay = 120'(data >> (k * 120));
      pkt[511 - k*128 -: 128] = {1'b1, (k == 0), (k == nf - 1), dest, 1'b0, pay};
    end
    return pkt;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [299:0] rand300();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[299:0];
  endfunction

  // One cycle: check outputs against the queue model, then advance it across the clock edge.
  task automatic step();
    logic         acc_a, pop_a, acc_b, pop_b, exp_ra, exp_rb;
    logic [511:0] pa, pb;
    exp_ra = armed && (qa.size() < 2);
    exp_rb = armed && (qb.size() < 2);
    chk("a_ready", 512'(a_rdy_out), 512'(exp_ra));
    chk("a_valid", 512'(a_vout), 512'(qa.size() > 0));
    if (qa.size() > 0) chk("a_data", a_dout, qa[0]);
    chk("b_ready", 512'(b_rdy_out), 512'(exp_rb));
    chk("b_valid", 512'(b_vout), 512'(qb.size() > 0));
    if (qb.size() > 0) chk("b_data", b_dout, qb[0]);
    acc_a = a_vin && exp_ra;
    pop_a = (qa.size() > 0) && a_rdy_in;
    acc_b = b_vin && exp_rb;
    pop_b = (qb.size() > 0) && b_rdy_in;
    pa    = model_pkt(300'(a_data), a_dest, 19);
    pb    = model_pkt(b_data, b_dest, 300);
    @(posedge clk);
    if (pop_a) void'(qa.pop_front());
    if (acc_a) qa.push_back(pa);
    if (pop_b) void'(qb.pop_front());
    if (acc_b) qb.push_back(pb);
    armed = rst;
    @(negedge clk);
  endtask

  initial begin
    logic [511:0] exp;
    logic [299:0] bd;
    tests  = 0;
    fails  = 0;
    armed  = 1'b0;
    rst    = 1'b0;
    a_data = '0; a_dest = '0; a_vin = 1'b0; a_rdy_in = 1'b1;
    b_data = '0; b_dest = '0; b_vin = 1'b0; b_rdy_in = 1'b1;

    // Reset state
    #3;
    chk("rst_a_valid", 512'(a_vout), 512'(0));
    chk("rst_a_ready", 512'(a_rdy_out), 512'(0));
    chk("rst_a_data", a_dout, 512'(0));
    chk("rst_b_valid", 512'(b_vout), 512'(0));
    chk("rst_b_data", b_dout, 512'(0));
    @(negedge clk);
    rst = 1'b1;
    step();
    step();

    // Single word with the documented layout
    a_vin = 1'b1; a_data = 19'h5A5A5; a_dest = 4'hF;
    step();
    a_vin = 1'b0; a_data = '1;
    exp = '0;
    exp[511:509] = 3'b111;
    exp[508:505] = 4'hF;
    exp[402:384] = 19'h5A5A5;
    chk("single_valid", 512'(a_vout), 512'(1));
    chk("single_pkt", a_dout, exp);
    step();

    // Three-flit instance
    bd = rand300();
    b_vin = 1'b1; b_data = bd; b_dest = 4'h9;
    step();
    b_vin = 1'b0;
    chk("mf_head0", 512'(b_dout[510]), 512'(1));
    chk("mf_tail0", 512'(b_dout[509]), 512'(0));
    chk("mf_tail2", 512'(b_dout[253]), 512'(1));
    chk("mf_pay2", 512'(b_dout[247:128]), 512'(bd[299:240]));
    chk("mf_flit3", 512'(b_dout[127:0]), 512'(0));
    step();

    // Backpressure: three offered, two taken, then drained in order
    a_rdy_in = 1'b0; a_vin = 1'b1;
    a_data = 19'h11111; a_dest = 4'h1; step();
    a_data = 19'h22222; a_dest = 4'h2; step();
    a_data = 19'h33333; a_dest = 4'h3;
    chk("bp_ready_low", 512'(a_rdy_out), 512'(0));
    step();
    step();
    a_rdy_in = 1'b1;
    while (qa.size() == 2 || a_vin) begin
      if (a_vin && a_rdy_out === 1'b1 && qa.size() < 2) begin
        step();
        a_vin = 1'b0;
      end else begin
        step();
      end
      if (tests > 5000) break;
    end
    for (int i = 0; i < 4; i++) step();

    // Streaming
    a_vin = 1'b1; a_rdy_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a_data = 19'($urandom); a_dest = 4'($urandom);
      step();
    end
    a_vin = 1'b0;
    step();

    // Random traffic on both instances
    for (int i = 0; i < 300; i++) begin
      a_vin = 1'($urandom); a_rdy_in = 1'($urandom); a_data = 19'($urandom);
      a_dest = 4'($urandom);
      b_vin = 1'($urandom); b_rdy_in = 1'($urandom); b_data = rand300();
      b_dest = 4'($urandom);
      step();
    end

    // Reset with both entries full
    a_vin = 1'b1; a_rdy_in = 1'b0; b_vin = 1'b1; b_rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("full_a", 512'(qa.size()), 512'(2));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_a_valid", 512'(a_vout), 512'(0));
    chk("mid_rst_a_ready", 512'(a_rdy_out), 512'(0));
    chk("mid_rst_a_data", a_dout, 512'(0));
    chk("mid_rst_b_valid", 512'(b_vout), 512'(0));
    qa.delete();
    qb.delete();
    armed = 1'b0;
    @(negedge clk);
    a_vin = 1'b0; a_rdy_in = 1'b1; b_vin = 1'b0; b_rdy_in = 1'b1;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/packetizer.md
PACKETIZER -- requirements
Module: packetizer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 4: width of the destination node address.
REQ-002 Parameter VC_ADDRESS_WIDTH, default 1: width of the virtual-channel (VC) field.
REQ-003 Parameter WIDTH_IN, default 19: width of the user data word.
REQ-004 Parameter WIDTH_OUT, default 512: width of the fabric packet; holds 4 flits of FLIT_W = WIDTH_OUT/4 bits each.
REQ-005 Parameter ASSIGNED_VC, default 0: VC written into every flit.
REQ-006 Ports, clock and reset first:
- clk input 1: the single clock.
- rst input 1: asynchronous, active-low reset.
- i_data_in input WIDTH_IN: user data.
- i_dest_in input ADDRESS_WIDTH: destination node.
- i_valid_in input 1: input word valid.
- i_ready_out output 1: packetizer can accept a word.
- o_data_out output WIDTH_OUT: packet to the fabric.
- o_valid_out output 1: packet valid.
- o_ready_in input 1: fabric accepts the packet.

Function
REQ-007 Payload width per flit SHALL be P = FLIT_W-3-ADDRESS_WIDTH-VC_ADDRESS_WIDTH; flit count SHALL be NF = ceil(WIDTH_IN/P).
REQ-008 Elaboration SHALL fail if NF > 4 or P < 1.
REQ-009 Flit k SHALL occupy o_data_out[WIDTH_OUT-1-k*FLIT_W -: FLIT_W], so flit 0 is at the MSBs.
REQ-010 Flit layout, MSB first: valid (1), head (1), tail (1), dest (ADDRESS_WIDTH), vc (VC_ADDRESS_WIDTH), payload (P).
REQ-011 Flit k payload SHALL carry i_data_in[k*P +: P], right-aligned and zero-extended in the last flit.
REQ-012 Flits 0..NF-1 SHALL have valid=1 and carry dest=i_dest_in and vc=ASSIGNED_VC.
REQ-013 Flit 0 SHALL have head=1; flit NF-1 SHALL have tail=1; when NF=1 one flit SHALL have both set.
REQ-014 Flits NF..3 SHALL be all zeros.
REQ-015 A word SHALL be accepted only in a cycle with i_valid_in=1 and i_ready_out=1.
REQ-016 A packet SHALL transfer only in a cycle with o_valid_out=1 and o_ready_in=1.
REQ-017 Latency SHALL be exactly 1 cycle: a word accepted in cycle t appears on the outputs with o_valid_out=1 in cycle t+1.
REQ-018 Outputs SHALL come from registers; i_ready_out SHALL be a register output with no combinational path from o_ready_in.
REQ-019 Buffering SHALL be a 2-entry skid buffer: one main output register plus one skid register.
REQ-020 i_ready_out SHALL be 1 exactly when the skid register is empty.
REQ-021 Throughput SHALL be one packet per cycle while o_ready_in stays 1.
REQ-022 When o_ready_in=0 and the main register is full, an accepted word SHALL go to the skid register and i_ready_out SHALL drop the next cycle.
REQ-023 When o_ready_in returns to 1, the skid entry SHALL move to the main register, and i_ready_out SHALL rise the next cycle.
REQ-024 Accept and transfer in the same cycle SHALL neither lose nor duplicate a packet.
REQ-025 Packet order SHALL be preserved.
REQ-026 While o_valid_out=1 and o_ready_in=0, o_data_out SHALL hold stable.
REQ-027 i_data_in and i_dest_in SHALL be ignored when i_valid_in=0.

Reset
REQ-028 While rst=0: o_valid_out=0, o_data_out=0, i_ready_out=0, and both buffer entries are empty; these take effect asynchronously.
REQ-029 i_ready_out SHALL be 1 on the first clk edge after rst deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered packets; none SHALL appear after reset.

Structure
REQ-031 A shared package SHALL hold:
- the flit field offset constants and FLIT_W;
- a function computing P and NF from the parameters;
- a function building one flit from (valid, head, tail, dest, vc, payload).
REQ-032 The depacketizer SHALL reuse the same package.
REQ-033 One sub-module, pkt_skid_buffer, SHALL be a parameterised-width 2-entry ready/valid register slice; packet formatting SHALL stay combinational in the top module.

Verification
Default parameters give P=120 and NF=1.
REQ-034 Single word: rst released, i_data_in=19'h5A5A5, i_dest_in=15, o_ready_in=1 → next cycle o_valid_out=1.
- o_data_out[511:509]=3'b111 and [508:505]=4'hF.
- [504]=0, [402:384]=19'h5A5A5, and every other bit 0.
REQ-035 Backpressure: o_ready_in=0 while 3 words are offered → 2 accepted and i_ready_out=0.
- After o_ready_in=1, words 1, 2, 3 emerge in order with no loss or duplication.
REQ-036 Multi-flit (WIDTH_IN=300, NF=3):
- flit 0 head=1 tail=0, flit 2 tail=1;
- flit 2 payload = data[299:240] zero-extended;
- flit 3 all zeros.
REQ-037 Streaming: 100 back-to-back words with o_ready_in=1 → 100 packets on consecutive cycles with latency 1.
REQ-038 Reset: assert rst with both entries full → o_valid_out=0 immediately, and no stale packet appears after release.
